// File: rtl/vvp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vvp_pkg
// Brief    : Shared mode encodings, per-element term function and plane-sum
//            width helper for the bit-serial vector-vector product.
// Revision : 1.0
// ============================================================================
package vvp_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'b00,
        MODE_POS  = 2'b01,
        MODE_PM   = 2'b10,
        MODE_NEG  = 2'b11
    } vvp_mode_e;

    // Width of a signed sum of n terms, each in {-1, 0, +1}.
    function automatic int vvp_sum_w(input int n);
        return $clog2(n) + 2;
    endfunction

    function automatic logic signed [1:0] vvp_term(
        input logic [1:0] mode,
        input logic       w,
        input logic       d
    );
        logic signed [1:0] r_term;
        r_term = 2'sb00;
        case (mode)
            MODE_POS: r_term = (w & d) ? 2'sb01 : 2'sb00;
            MODE_PM:  r_term = d ? (w ? 2'sb11 : 2'sb01) : 2'sb00;
            MODE_NEG: r_term = (w & d) ? 2'sb11 : 2'sb00;
            default:  r_term = 2'sb00;
        endcase
        return r_term;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vvp_tree.sv
`default_nettype none
// ============================================================================
// Module   : vvp_tree
// Brief    : Recursive signed adder tree over 2-bit terms with optional
//            register stages and a tag bus delayed alongside the data.
// Revision : 1.0
// ============================================================================
module vvp_tree
    import vvp_pkg::*;
#(
    parameter int N     = 64,
    parameter int PIPE  = 0,
    parameter int DEPTH = $clog2(N),
    parameter int TW    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [2*N-1:0]                  i_terms,
    input  logic [TW-1:0]                   i_tag,
    output logic signed [vvp_sum_w(N)-1:0]  o_sum,
    output logic [TW-1:0]                   o_tag
);

    localparam int c_sw = vvp_sum_w(N);

    generate
        if (N == 1) begin : g_leaf
            logic w_unused_clk;
            assign w_unused_clk = clk ^ rst_n;
            assign o_sum        = i_terms;
            assign o_tag        = i_tag;
        end else begin : g_node
            localparam int c_half = N / 2;
            localparam int c_lvl  = $clog2(N);
            // Stage boundaries land where ceil(level*PIPE/DEPTH) steps up,
            // which places the first register nearest the leaves.
            localparam bit c_reg =
                (((c_lvl * PIPE) + DEPTH - 1) / DEPTH) >
                ((((c_lvl - 1) * PIPE) + DEPTH - 1) / DEPTH);

            logic signed [c_sw-2:0] w_sum_lo;
            logic signed [c_sw-2:0] w_sum_hi;
            logic [TW-1:0]          w_tag_lo;
            logic [TW-1:0]          w_tag_hi;
            logic signed [c_sw-1:0] w_add;
            logic [TW-1:0]          w_tag;

            vvp_tree #(
                .N     (c_half),
                .PIPE  (PIPE),
                .DEPTH (DEPTH),
                .TW    (TW)
            ) u_lo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_terms (i_terms[2*c_half-1:0]),
                .i_tag   (i_tag),
                .o_sum   (w_sum_lo),
                .o_tag   (w_tag_lo)
            );

            vvp_tree #(
                .N     (c_half),
                .PIPE  (PIPE),
                .DEPTH (DEPTH),
                .TW    (TW)
            ) u_hi (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_terms (i_terms[2*N-1:2*c_half]),
                .i_tag   (i_tag),
                .o_sum   (w_sum_hi),
                .o_tag   (w_tag_hi)
            );

            assign w_add = {w_sum_lo[c_sw-2], w_sum_lo} + {w_sum_hi[c_sw-2], w_sum_hi};
            // Both halves carry identical tags; combining keeps both paths live.
            assign w_tag = w_tag_lo & w_tag_hi;

            if (c_reg) begin : g_reg
                logic signed [c_sw-1:0] r_sum;
                logic [TW-1:0]          r_tag;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sum <= '0;
                        r_tag <= '0;
                    end else begin
                        r_sum <= w_add;
                        r_tag <= w_tag;
                    end
                end

                assign o_sum = r_sum;
                assign o_tag = r_tag;
            end else begin : g_comb
                assign o_sum = w_add;
                assign o_tag = w_tag;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vvp_bitserial.sv
`default_nettype none
// ============================================================================
// Module   : vvp_bitserial
// Brief    : Bit-serial multi-bit vector-vector product: plane tracking,
//            per-plane shift/negate, accumulation and result register.
// Revision : 1.0
// ============================================================================
module vvp_bitserial
    import vvp_pkg::*;
#(
    parameter int N     = 64,
    parameter int DPREC = 8,
    parameter int ACCW  = 16,
    parameter int PIPE  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    dsigned,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [N-1:0]            W,
    input  logic [N-1:0]            D,
    output logic                    out_valid,
    output logic signed [ACCW-1:0]  out_S,
    output logic                    out_ovf
);

    localparam int c_depth = $clog2(N);
    localparam int c_np    = 1 << c_depth;
    localparam int c_sw    = vvp_sum_w(N);
    localparam int c_kw    = (DPREC > 1) ? $clog2(DPREC) : 1;
    localparam int c_tw    = c_kw + 4;
    localparam int c_xw    = ((c_sw + DPREC > ACCW) ? (c_sw + DPREC) : ACCW) + 1;

    logic              r_open;
    logic [c_kw-1:0]   r_k;
    logic [1:0]        r_mode;
    logic              r_dsgn;

    logic              w_first;
    logic              w_cont;
    logic              w_accept;
    logic              w_last;
    logic              w_dsgn;
    logic [c_kw-1:0]   w_k;
    logic [1:0]        w_mode;
    logic [2*c_np-1:0] w_terms;
    logic [c_tw-1:0]   w_tag_in;

    assign w_first  = in_valid & in_first;
    assign w_cont   = in_valid & ~in_first & r_open;
    assign w_accept = w_first | w_cont;
    assign w_k      = w_first ? '0 : r_k;
    assign w_last   = in_last | (w_k == c_kw'(DPREC - 1));
    assign w_mode   = w_first ? mode    : r_mode;
    assign w_dsgn   = w_first ? dsigned : r_dsgn;

    // Tree is padded to a power of two with zero terms.
    generate
        for (genvar gi = 0; gi < c_np; gi++) begin : g_term
            if (gi < N) begin : g_real
                assign w_terms[2*gi +: 2] = vvp_term(w_mode, W[gi], D[gi]);
            end else begin : g_pad
                assign w_terms[2*gi +: 2] = 2'b00;
            end
        end
    endgenerate

    // Plane metadata travels with the data so the back end needs no
    // knowledge of vectors that have since been opened or aborted.
    assign w_tag_in = {w_k, w_dsgn, w_last, w_first, w_accept};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_open <= 1'b0;
            r_k    <= '0;
            r_mode <= MODE_ZERO;
            r_dsgn <= 1'b0;
        end else if (w_accept) begin
            r_open <= ~w_last;
            r_k    <= w_k + c_kw'(1);
            if (w_first) begin
                r_mode <= mode;
                r_dsgn <= dsigned;
            end
        end
    end

    logic signed [c_sw-1:0] w_sp;
    logic [c_tw-1:0]        w_tag_out;

    vvp_tree #(
        .N     (c_np),
        .PIPE  (PIPE),
        .DEPTH (c_depth),
        .TW    (c_tw)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_terms (w_terms),
        .i_tag   (w_tag_in),
        .o_sum   (w_sp),
        .o_tag   (w_tag_out)
    );

    logic                   w_t_valid;
    logic                   w_t_first;
    logic                   w_t_last;
    logic                   w_t_dsgn;
    logic [c_kw-1:0]        w_t_k;
    logic signed [c_xw-1:0] w_shift;
    logic signed [c_xw-1:0] w_c_wide;
    logic signed [ACCW-1:0] w_c;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_acc_nx;
    logic                   w_c_ovf;
    logic                   w_add_ovf;
    logic                   w_ovf_nx;

    logic signed [ACCW-1:0] r_acc;
    logic                   r_ovf;
    logic                   r_out_valid;
    logic signed [ACCW-1:0] r_out_s;
    logic                   r_out_ovf;

    assign {w_t_k, w_t_dsgn, w_t_last, w_t_first, w_t_valid} = w_tag_out;

    // The MSB plane of two's-complement data carries negative weight.
    assign w_shift  = {{(c_xw - c_sw){w_sp[c_sw-1]}}, w_sp} <<< w_t_k;
    assign w_c_wide = (w_t_dsgn & w_t_last) ? -w_shift : w_shift;
    assign w_c      = w_c_wide[ACCW-1:0];
    assign w_c_ovf  = (w_c_wide[c_xw-1:ACCW-1] != {(c_xw - ACCW + 1){w_c_wide[ACCW-1]}});

    assign w_sum     = r_acc + w_c;
    assign w_add_ovf = (r_acc[ACCW-1] == w_c[ACCW-1]) && (w_sum[ACCW-1] != r_acc[ACCW-1]);
    assign w_acc_nx  = w_t_first ? w_c : w_sum;
    assign w_ovf_nx  = w_c_ovf | (~w_t_first & (r_ovf | w_add_ovf));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_valid <= w_t_valid & w_t_last;
            if (w_t_valid) begin
                r_acc <= w_acc_nx;
                r_ovf <= w_ovf_nx;
                if (w_t_last) begin
                    r_out_s   <= w_acc_nx;
                    r_out_ovf <= w_ovf_nx;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_S     = r_out_s;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vvp_bitserial.sv
`default_nettype none
// ============================================================================
// Module   : tb_vvp_bitserial
// Brief    : Scoreboard bench driving two vvp_bitserial configurations with
//            shared stimulus and checking against a dot-product model.
// Revision : 1.0
// ============================================================================
module tb_vvp_bitserial;

    localparam int N      = 64;
    localparam int DPREC  = 8;
    localparam int PIPE_A = 2;
    localparam int ACCW_A = 16;
    localparam int PIPE_B = 1;
    localparam int ACCW_B = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              dsigned = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic [N-1:0]      W = '0;
    logic [N-1:0]      D = '0;
    logic              out_valid_a, out_ovf_a, out_valid_b, out_ovf_b;
    logic [ACCW_A-1:0] out_s_a;
    logic [ACCW_B-1:0] out_s_b;

    always #5 clk = ~clk;

    vvp_bitserial #(.N(N), .DPREC(DPREC), .ACCW(ACCW_A), .PIPE(PIPE_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .dsigned(dsigned),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .W(W), .D(D), .out_valid(out_valid_a), .out_S(out_s_a), .out_ovf(out_ovf_a)
    );

    vvp_bitserial #(.N(N), .DPREC(DPREC), .ACCW(ACCW_B), .PIPE(PIPE_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .dsigned(dsigned),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .W(W), .D(D), .out_valid(out_valid_b), .out_S(out_s_b), .out_ovf(out_ovf_b)
    );

    typedef struct {
        logic [15:0] s;
        bit          ovf;
        int          cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [63:0] g_pl[16];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint weight_val(input logic [1:0] m, input logic w);
        case (m)
            2'b01:   return w ? 64'sd1 : 64'sd0;
            2'b10:   return w ? -64'sd1 : 64'sd1;
            2'b11:   return w ? -64'sd1 : 64'sd0;
            default: return 64'sd0;
        endcase
    endfunction

    function automatic longint wrap(input longint v, input int accw);
        longint m;
        m = v & ((longint'(1) << accw) - 1);
        if (m >= (longint'(1) << (accw - 1))) m = m - (longint'(1) << accw);
        return m;
    endfunction

    // Result is the plain dot product of element values; overflow follows the
    // plane-by-plane accumulation in an ACCW-bit register.
    function automatic void model(input logic [1:0] m, input logic ds, input logic [63:0] w,
                                  input int np, input int accw, output longint s, output bit ovf);
        longint dot, x, sp, c, acc, sm, hi, lo;
        dot = 0;
        for (int i = 0; i < N; i++) begin
            x = 0;
            for (int k = 0; k < np; k++)
                if (g_pl[k][i]) x += longint'(1) << k;
            if (ds && g_pl[np-1][i]) x -= longint'(1) << np;
            dot += weight_val(m, w[i]) * x;
        end
        s   = dot & ((longint'(1) << accw) - 1);
        hi  = (longint'(1) << (accw - 1)) - 1;
        lo  = -(longint'(1) << (accw - 1));
        ovf = 1'b0;
        acc = 0;
        for (int k = 0; k < np; k++) begin
            sp = 0;
            for (int i = 0; i < N; i++)
                if (g_pl[k][i]) sp += weight_val(m, w[i]);
            c = sp * (longint'(1) << k);
            if (ds && k == np - 1) c = -c;
            if (c > hi || c < lo) ovf = 1'b1;
            c = wrap(c, accw);
            if (k == 0) begin
                acc = c;
            end else begin
                sm = acc + c;
                if (sm > hi || sm < lo) ovf = 1'b1;
                acc = wrap(sm, accw);
            end
        end
    endfunction

    always @(posedge clk) begin : mon_a
        exp_t e;
        #1;
        if (out_valid_a) begin
            if (qa.size() == 0) begin
                check("A_unexpected_pulse", 1, 0);
            end else begin
                e = qa.pop_front();
                check("A_out_S", longint'(out_s_a), longint'(e.s));
                check("A_out_ovf", longint'(out_ovf_a), longint'(e.ovf));
                check("A_latency_cycle", cyc, e.cyc);
            end
        end
    end

    always @(posedge clk) begin : mon_b
        exp_t e;
        #1;
        if (out_valid_b) begin
            if (qb.size() == 0) begin
                check("B_unexpected_pulse", 1, 0);
            end else begin
                e = qb.pop_front();
                check("B_out_S", longint'(out_s_b), longint'(e.s[ACCW_B-1:0]));
                check("B_out_ovf", longint'(out_ovf_b), longint'(e.ovf));
                check("B_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic set_const(input logic [15:0] v);
        for (int k = 0; k < 16; k++) g_pl[k] = {64{v[k]}};
    endtask

    task automatic set_rand();
        for (int k = 0; k < 16; k++) g_pl[k] = {$urandom, $urandom};
    endtask

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = noise ? 1'($urandom) : 1'b0;
            in_first = 1'b0;
            in_last  = 1'($urandom);
            D        = {$urandom, $urandom};
            mode     = 2'($urandom);
            dsigned  = 1'($urandom);
        end
    endtask

    // nsend < np leaves the vector open (to be aborted or reset).
    task automatic run_vec(input logic [1:0] m, input logic ds, input logic [63:0] w,
                           input int np, input int nsend, input bit mark_last, input int bub_pct);
        longint sa, sb;
        bit     oa, ob;
        exp_t   ea, eb;
        model(m, ds, w, np, ACCW_A, sa, oa);
        model(m, ds, w, np, ACCW_B, sb, ob);
        for (int p = 0; p < nsend; p++) begin
            if (p > 0 && int'($urandom_range(99)) < bub_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_first = 1'($urandom);
                in_last  = 1'($urandom);
                D        = {$urandom, $urandom};
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_first = (p == 0);
            in_last  = mark_last && (p == np - 1);
            W        = w;
            D        = g_pl[p];
            mode     = (p == 0) ? m  : 2'($urandom);
            dsigned  = (p == 0) ? ds : 1'($urandom);
            if (p == np - 1) begin
                ea.s = 16'(sa); ea.ovf = oa; ea.cyc = cyc + 1 + PIPE_A;
                eb.s = 16'(sb); eb.ovf = ob; eb.cyc = cyc + 1 + PIPE_B;
                qa.push_back(ea);
                qb.push_back(eb);
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [1:0]  m;
        logic        ds;
        logic [63:0] w;
        int          np;
        bit          ml;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid_A", longint'(out_valid_a), 0);
        check("rst_out_S_A", longint'(out_s_a), 0);
        check("rst_out_ovf_A", longint'(out_ovf_a), 0);
        check("rst_out_valid_B", longint'(out_valid_b), 0);
        check("rst_out_S_B", longint'(out_s_b), 0);
        check("rst_out_ovf_B", longint'(out_ovf_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b1);

        set_const(16'd3);
        run_vec(2'b10, 1'b0, 64'h0, 2, 2, 1'b1, 0);
        idle(4, 1'b0);

        set_const(16'hFF);
        run_vec(2'b01, 1'b1, '1, 8, 8, 1'b1, 0);
        run_vec(2'b00, 1'b1, '1, 8, 8, 1'b0, 0);
        idle(3, 1'b1);

        set_const(16'd5);
        run_vec(2'b11, 1'b0, '1, 3, 3, 1'b1, 100);
        idle(3, 1'b0);

        set_const(16'd1);
        run_vec(2'b01, 1'b1, '1, 1, 1, 1'b1, 0);
        set_const(16'd2);
        run_vec(2'b01, 1'b0, '1, 2, 2, 1'b1, 0);
        idle(4, 1'b0);

        set_const(16'd3);
        run_vec(2'b01, 1'b0, '1, 4, 2, 1'b1, 0);
        set_const(16'd1);
        run_vec(2'b01, 1'b0, '1, 1, 1, 1'b1, 0);
        idle(4, 1'b0);

        set_const(16'd255);
        run_vec(2'b01, 1'b0, '1, 8, 8, 1'b1, 0);
        set_const(16'd1);
        run_vec(2'b01, 1'b0, '1, 1, 1, 1'b1, 0);
        idle(6, 1'b0);

        set_const(16'd3);
        run_vec(2'b01, 1'b0, '1, 4, 2, 1'b1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid_A", longint'(out_valid_a), 0);
        check("midrst_out_S_A", longint'(out_s_a), 0);
        check("midrst_out_valid_B", longint'(out_valid_b), 0);
        check("midrst_out_S_B", longint'(out_s_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10, 1'b1);
        check("postrst_out_S_A", longint'(out_s_a), 0);
        check("postrst_out_S_B", longint'(out_s_b), 0);

        for (int it = 0; it < 60; it++) begin
            m  = 2'($urandom);
            ds = 1'($urandom);
            w  = {$urandom, $urandom};
            np = int'($urandom_range(1, DPREC));
            ml = (np == DPREC) ? 1'($urandom) : 1'b1;
            set_rand();
            if (np >= 2 && $urandom_range(7) == 0) begin
                run_vec(m, ds, w, np, int'($urandom_range(1, np - 1)), ml, 20);
            end else begin
                run_vec(m, ds, w, np, np, ml, 20);
                idle(int'($urandom_range(0, 2)), 1'b1);
            end
        end
        set_rand();
        run_vec(2'b10, 1'b1, {$urandom, $urandom}, 4, 4, 1'b1, 0);
        idle(PIPE_A + 6, 1'b0);

        check("A_queue_drained", qa.size(), 0);
        check("B_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
